// File: rtl/wasm_exec_core_if.sv
// Shared byte-memory bus between the executor core (master) and the
// arbiter/memory side (slave).
//
// Handshake:
//   - mem_access is the arbiter's grant. The master drives mem_addr,
//     mem_data_in, mem_read_en and mem_write_en only while it is 1 and
//     releases them to Z otherwise.
//   - Read: the master holds mem_addr and mem_read_en=1 until a cycle in
//     which mem_ready=1; mem_data_out is valid in that cycle. The master
//     then drops mem_read_en for at least one cycle before the next read.
//   - Write: mem_addr, mem_data_in and mem_write_en=1 are presented for
//     exactly one granted cycle; there is no ready handshake for writes.
//
// Signals:
//   mem_access    slave->master  bus grant
//   mem_addr      master->slave  32-bit byte address
//   mem_data_in   master->slave  8-bit write data
//   mem_data_out  slave->master  8-bit read data
//   mem_read_en   master->slave  read request (level, held until ready)
//   mem_write_en  master->slave  single-cycle write strobe
//   mem_ready     slave->master  one-cycle read-data-valid pulse
interface wasm_exec_core_if;
  logic        mem_access;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out;
  logic        mem_read_en;
  logic        mem_write_en;
  logic        mem_ready;

  modport master (
    input  mem_access, mem_data_out, mem_ready,
    output mem_addr, mem_data_in, mem_read_en, mem_write_en
  );

  modport slave (
    output mem_access, mem_data_out, mem_ready,
    input  mem_addr, mem_data_in, mem_read_en, mem_write_en
  );
endinterface

// File: rtl/wasm_exec_core.sv
// Byte-wide WebAssembly stack-machine executor.
//
// Waits for the loader (rom_mapped), then fetches opcodes from shared byte
// memory starting at first_instruction. The operand stack lives in the same
// memory starting at OP_STACK_TOP and grows upward; sp always points at the
// next free slot, so the top of stack is at sp-1.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   bus                memory bus (master side), tri-stated while not granted
//   rom_mapped         level start request from the loader
//   first_instruction  byte address of the first opcode
//   stack_top          current stack pointer (next free slot)
//   dbg_state          current FSM state for inspection
module wasm_exec_core #(
  parameter logic [7:0] OP_STACK_TOP = 8'h80,
  parameter logic [7:0] STACK_LIMIT  = 8'hFF
) (
  input  logic                    clk,
  input  logic                    reset,
  wasm_exec_core_if.master        bus,
  input  logic                    rom_mapped,
  input  logic [31:0]             first_instruction,
  output logic [7:0]              stack_top,
  output logic [3:0]              dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_IMM, S_POPB,
    S_POPA, S_EXEC, S_PUSH, S_HALT, S_TRAP
  } state_t;

  // sp carries a ninth bit so a push past STACK_LIMIT is detectable
  // instead of silently wrapping to slot 0.
  localparam logic [8:0] SP_EMPTY = {1'b0, OP_STACK_TOP};
  localparam logic [8:0] SP_LIMIT = {1'b0, STACK_LIMIT};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [8:0]  sp_q, sp_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  val_q, val_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [1:0]  imm_cnt_q, imm_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;

  logic        granted;
  logic [7:0]  rdata;
  logic        rvalid;

  assign granted = bus.mem_access;
  assign rdata   = bus.mem_data_out;
  // rd_q doubles as "read in flight": it is 0 on entry to every read state,
  // so the first granted cycle issues the request and a later ready
  // completes it. The cycle after completion always has rd_q=0.
  assign rvalid  = rd_q & bus.mem_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    ir_d      = ir_q;
    val_d     = val_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_cnt_d = imm_cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;

    // Without the grant everything holds; a pending read stays requested
    // and is presented again as soon as the bus comes back.
    if (granted) begin
      case (state_q)
        S_IDLE: begin
          if (rom_mapped) begin
            pc_d    = first_instruction;
            state_d = S_FETCH;
          end
        end

        S_FETCH: begin
          if (!rd_q) begin
            rd_d   = 1'b1;
            addr_d = pc_q;
          end else if (rvalid) begin
            rd_d    = 1'b0;
            ir_d    = rdata;
            pc_d    = pc_q + 32'd1;
            state_d = S_DECODE;
          end
        end

        S_DECODE: begin
          case (ir_q)
            8'h01: state_d = S_FETCH;
            8'h0B: state_d = S_HALT;
            8'h41: begin
              imm_cnt_d = 2'd0;
              state_d   = S_IMM;
            end
            8'h1A: begin
              if (sp_q == SP_EMPTY) begin
                state_d = S_TRAP;
              end else begin
                sp_d    = sp_q - 9'd1;
                state_d = S_FETCH;
              end
            end
            8'h6A, 8'h6B, 8'h71, 8'h72, 8'h73: state_d = S_POPB;
            default: state_d = S_TRAP;
          endcase
        end

        // LEB128 immediate, truncated to 8 bits: byte 0 gives bits 6:0,
        // byte 1 (if present) gives bit 7, any further bytes are skipped
        // until one has bit 7 clear.
        S_IMM: begin
          if (!rd_q) begin
            rd_d   = 1'b1;
            addr_d = pc_q;
          end else if (rvalid) begin
            rd_d = 1'b0;
            pc_d = pc_q + 32'd1;
            case (imm_cnt_q)
              2'd0: begin
                val_d = {rdata[6], rdata[6:0]};
                if (rdata[7]) imm_cnt_d = 2'd1;
                else          state_d   = S_PUSH;
              end
              2'd1: begin
                val_d = {rdata[0], val_q[6:0]};
                if (rdata[7]) imm_cnt_d = 2'd2;
                else          state_d   = S_PUSH;
              end
              default: begin
                if (!rdata[7]) state_d = S_PUSH;
              end
            endcase
          end
        end

        S_POPB, S_POPA: begin
          if (!rd_q) begin
            if (sp_q == SP_EMPTY) begin
              state_d = S_TRAP;
            end else begin
              sp_d   = sp_q - 9'd1;
              addr_d = {23'd0, sp_q - 9'd1};
              rd_d   = 1'b1;
            end
          end else if (rvalid) begin
            rd_d = 1'b0;
            if (state_q == S_POPB) begin
              b_d     = rdata;
              state_d = S_POPA;
            end else begin
              a_d     = rdata;
              state_d = S_EXEC;
            end
          end
        end

        S_EXEC: begin
          case (ir_q)
            8'h6A:   val_d = a_q + b_q;
            8'h6B:   val_d = a_q - b_q;
            8'h71:   val_d = a_q & b_q;
            8'h72:   val_d = a_q | b_q;
            default: val_d = a_q ^ b_q;
          endcase
          state_d = S_PUSH;
        end

        // First granted cycle raises the strobe, the next one retires it,
        // so the strobe is seen for exactly one granted cycle.
        S_PUSH: begin
          if (!wr_q) begin
            if (sp_q > SP_LIMIT) begin
              state_d = S_TRAP;
            end else begin
              wr_d    = 1'b1;
              addr_d  = {23'd0, sp_q};
              wdata_d = val_q;
            end
          end else begin
            wr_d    = 1'b0;
            sp_d    = sp_q + 9'd1;
            state_d = S_FETCH;
          end
        end

        default: begin
          rd_d = 1'b0;
          wr_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= 32'd0;
      sp_q      <= SP_EMPTY;
      ir_q      <= 8'd0;
      val_q     <= 8'd0;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      imm_cnt_q <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 8'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      ir_q      <= ir_d;
      val_q     <= val_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_cnt_q <= imm_cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
    end
  end

  assign bus.mem_addr     = granted ? addr_q  : 'z;
  assign bus.mem_data_in  = granted ? wdata_q : 'z;
  assign bus.mem_read_en  = granted ? rd_q    : 1'bz;
  assign bus.mem_write_en = granted ? wr_q    : 1'bz;

  assign stack_top = sp_q[7:0];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wasm_exec_core.sv
module tb_wasm_exec_core;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        rom_mapped;
  logic [31:0] first_instruction;
  logic [7:0]  stack_top;
  logic [3:0]  dbg_state;

  always #5 clk = ~clk;

  wasm_exec_core_if bus();

  wasm_exec_core dut (
    .clk              (clk),
    .reset            (rst),
    .bus              (bus),
    .rom_mapped       (rom_mapped),
    .first_instruction(first_instruction),
    .stack_top        (stack_top),
    .dbg_state        (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory: rom is loaded by the stimulus process, wmem holds whatever the
  // core wrote since the last reset (and wins on reads).
  logic [7:0]  rom   [1024];
  logic [7:0]  wmem  [1024];
  bit          wvalid[1024];

  logic [17:0] exp_q[$];   // expected writes {addr[9:0], data}
  logic [17:0] obs_q[$];   // observed writes

  bit grant_en, rand_gaps, gap_arm, started;
  bit gap_done, rd_wait;
  int gap_left, lat_left, z_viol, early;

  function automatic logic [7:0] mem_at(input int a);
    return wvalid[a] ? wmem[a] : rom[a];
  endfunction

  // ---------------- memory / arbiter responder ----------------
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ready    = 1'b0;
      bus.mem_data_out = 8'h00;
      rd_wait  = 1'b0;
      lat_left = 0;
      gap_left = 0;
      gap_done = 1'b0;
      z_viol   = 0;
      early    = 0;
      for (int i = 0; i < 1024; i++) wvalid[i] = 1'b0;
      obs_q.delete();
      bus.mem_access = grant_en;
    end else begin
      bus.mem_ready = 1'b0;
      if (bus.mem_access) begin
        if (!started && (bus.mem_read_en === 1'b1 || bus.mem_write_en === 1'b1)) early++;
        if (bus.mem_write_en === 1'b1) begin
          wmem[bus.mem_addr[9:0]]   = bus.mem_data_in;
          wvalid[bus.mem_addr[9:0]] = 1'b1;
          obs_q.push_back({bus.mem_addr[9:0], bus.mem_data_in});
        end
        if (bus.mem_read_en === 1'b1) begin
          if (gap_arm && !gap_done) begin
            gap_done = 1'b1;
            gap_left = 5;
          end else begin
            if (!rd_wait) begin
              rd_wait  = 1'b1;
              lat_left = $urandom_range(0, 2);
            end
            if (lat_left == 0) begin
              bus.mem_data_out = mem_at(int'(bus.mem_addr[9:0]));
              bus.mem_ready    = 1'b1;
              rd_wait          = 1'b0;
            end else begin
              lat_left--;
            end
          end
        end
      end else if (bus.mem_read_en === 1'b1 || bus.mem_write_en === 1'b1) begin
        z_viol++;
      end
      if (gap_left == 0 && rand_gaps && $urandom_range(0, 15) == 0)
        gap_left = $urandom_range(1, 4);
      if (gap_left > 0) begin
        bus.mem_access = 1'b0;
        gap_left--;
      end else begin
        bus.mem_access = grant_en;
      end
    end
  end

  // ---------------- reference model ----------------
  // Interprets the program bytes with a plain value stack; every push is a
  // write to OP_STACK_TOP + depth.
  task automatic run_model(input int base, output int exp_sp);
    logic [7:0] stk[$];
    logic [7:0] op, b0, bx, a, b, v;
    int pc;
    bit done;
    exp_q.delete();
    pc = base;
    done = 1'b0;
    while (!done) begin
      op = rom[pc % 1024]; pc++;
      case (op)
        8'h01: ;
        8'h0B: done = 1'b1;
        8'h41: begin
          b0 = rom[pc % 1024]; pc++;
          if (!b0[7]) v = {b0[6], b0[6:0]};
          else begin
            bx = rom[pc % 1024]; pc++;
            v = {bx[0], b0[6:0]};
            while (bx[7]) begin bx = rom[pc % 1024]; pc++; end
          end
          if (stk.size() >= 128) done = 1'b1;
          else begin
            exp_q.push_back({10'(128 + stk.size()), v});
            stk.push_back(v);
          end
        end
        8'h1A: if (stk.size() == 0) done = 1'b1; else void'(stk.pop_back());
        8'h6A, 8'h6B, 8'h71, 8'h72, 8'h73: begin
          if (stk.size() == 0) done = 1'b1;
          else begin
            b = stk.pop_back();
            if (stk.size() == 0) done = 1'b1;
            else begin
              a = stk.pop_back();
              case (op)
                8'h6A:   v = a + b;
                8'h6B:   v = a - b;
                8'h71:   v = a & b;
                8'h72:   v = a | b;
                default: v = a ^ b;
              endcase
              exp_q.push_back({10'(128 + stk.size()), v});
              stk.push_back(v);
            end
          end
        end
        default: done = 1'b1;
      endcase
    end
    exp_sp = 128 + stk.size();
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit aborted = 1'b0;

  task automatic run_prog(input logic [7:0] prog[$], input int base,
                          input bit gaps, input bit arm, input bit drop_rom,
                          input string name);
    int exp_sp, idle, cyc, n;
    rst = 1'b1; rom_mapped = 1'b0; started = 1'b0;
    rand_gaps = gaps; gap_arm = arm; grant_en = 1'b1;
    for (int i = 0; i < 1024; i++)
      rom[i] = (i >= 128 && i < 256) ? 8'($urandom_range(0, 255)) : 8'h00;
    for (int i = 0; i < prog.size(); i++) rom[(base + i) % 1024] = prog[i];
    first_instruction = base;
    run_model(base, exp_sp);
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    rom_mapped = 1'b1; started = 1'b1;
    idle = 0; cyc = 0;
    while (idle < 24 && cyc < 4000) begin
      step();
      cyc++;
      if (drop_rom && cyc == 4) rom_mapped = 1'b0;
      if (bus.mem_read_en !== 1'b1 && bus.mem_write_en !== 1'b1) idle++;
      else idle = 0;
    end
    check({name, "_done"}, 32'(cyc < 4000), 32'd1);
    if (cyc >= 4000) aborted = 1'b1;
    check({name, "_sp"}, 32'(stack_top), 32'(exp_sp[7:0]));
    check({name, "_wr_cnt"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({name, "_wr"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({name, "_bus_released"}, z_viol, 0);
    check({name, "_early_access"}, early, 0);
  endtask

  task automatic gen_prog(output logic [7:0] p[$]);
    logic [7:0] binops[5];
    int n;
    binops = '{8'h6A, 8'h6B, 8'h71, 8'h72, 8'h73};
    p.delete();
    n = $urandom_range(3, 14);
    repeat (n) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          p.push_back(8'h41);
          case ($urandom_range(0, 2))
            0: p.push_back(8'($urandom_range(0, 127)));
            1: begin
              p.push_back(8'($urandom_range(128, 255)));
              p.push_back(8'($urandom_range(0, 127)));
            end
            default: begin
              p.push_back(8'($urandom_range(128, 255)));
              p.push_back(8'($urandom_range(128, 255)));
              p.push_back(8'($urandom_range(0, 127)));
            end
          endcase
        end
        4, 5, 6: p.push_back(binops[$urandom_range(0, 4)]);
        7: p.push_back(8'h1A);
        8: p.push_back(8'h01);
        default: p.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'h55);
      endcase
    end
    p.push_back(8'h0B);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] p[$];
    rst = 1'b1; rom_mapped = 1'b0; started = 1'b0; grant_en = 1'b0;
    rand_gaps = 1'b0; gap_arm = 1'b0; first_instruction = 32'h0;

    // reset with no grant: bus released, empty stack, no activity
    repeat (4) step();
    rst = 1'b0;
    repeat (5) step();
    check("rst_stack_top", 32'(stack_top), 32'h80);
    check("rst_bus_released", z_viol, 0);
    grant_en = 1'b1;
    repeat (6) step();
    check("idle_read_en", 32'(bus.mem_read_en), 32'd0);
    check("idle_write_en", 32'(bus.mem_write_en), 32'd0);
    check("idle_no_access", early, 0);

    p = '{8'h41, 8'h05, 8'h41, 8'h03, 8'h6A, 8'h0B};
    run_prog(p, 32'h20, 1'b0, 1'b0, 1'b0, "add");
    check("add_sp", 32'(stack_top), 32'h81);
    check("add_m80", 32'(mem_at(128)), 32'h08);

    p = '{8'h41, 8'h02, 8'h41, 8'h05, 8'h6B, 8'h0B};
    run_prog(p, 32'h20, 1'b0, 1'b0, 1'b0, "sub");
    check("sub_m80", 32'(mem_at(128)), 32'hFD);

    p = '{8'h41, 8'h80, 8'h01, 8'h41, 8'h7F, 8'h72, 8'h0B};
    run_prog(p, 32'h20, 1'b0, 1'b0, 1'b0, "leb_or");
    check("leb_or_m80", 32'(mem_at(128)), 32'hFF);

    p = '{8'h1A, 8'h41, 8'h01, 8'h0B};
    run_prog(p, 32'h20, 1'b0, 1'b0, 1'b0, "drop_empty");
    check("drop_empty_sp", 32'(stack_top), 32'h80);
    check("drop_empty_nowr", obs_q.size(), 0);

    p = '{8'h41, 8'h05, 8'h41, 8'h03, 8'h6A, 8'h0B};
    run_prog(p, 32'h20, 1'b0, 1'b1, 1'b0, "gap");
    check("gap_hit", 32'(gap_done), 32'd1);
    check("gap_m80", 32'(mem_at(128)), 32'h08);

    // 129 pushes: the last one finds sp past the limit
    p.delete();
    for (int i = 0; i < 129; i++) begin
      p.push_back(8'h41);
      p.push_back(8'($urandom_range(0, 127)));
    end
    p.push_back(8'h0B);
    run_prog(p, 32'h100, 1'b0, 1'b0, 1'b0, "overflow");

    for (int t = 0; t < 30 && !aborted; t++) begin
      gen_prog(p);
      run_prog(p, $urandom_range(0, 64), t[0], 1'b0, t[1], "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
